// File: rtl/aes_pkg.sv
// AES shared definitions: S-box and GF(2^8) helpers, round constants,
// the 4x4 byte state type with pack/unpack, and the core FSM encoding.
// No ports; imported by aes_enc_round and aes_iter_core.
package aes_pkg;

   // State matrix indexed [column][row]. Column 0 / row 0 sits in the MSB byte,
   // which is exactly the column-major FIPS-197 byte order of a 128-bit block.
   typedef logic [0:3][0:3][7:0] aes_state_t;

   typedef enum logic [2:0] {
      NOKEY,
      KEXP,
      READY,
      RUN,
      DONE
   } aes_fsm_e;

   // S-box table, entry 0 in the top byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Top bit of entry x is bit 2047-8x = 8*(255-x)+7 = {~x, 3'b111}.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[{~x, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic aes_state_t to_state(input logic [127:0] v);
      return aes_state_t'(v);
   endfunction

   function automatic logic [127:0] from_state(input aes_state_t s);
      return s;
   endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round.
// Ports:
//   data   - 128-bit state entering the round
//   rkey   - 128-bit round key, word 0 in [127:96]
//   last   - final round: MixColumns is bypassed
//   result - SubBytes, ShiftRows, (MixColumns), AddRoundKey applied to data
module aes_enc_round
   import aes_pkg::*;
(
   input  logic [127:0] data,
   input  logic [127:0] rkey,
   input  logic         last,
   output logic [127:0] result
);

   aes_state_t s, sb, sr, mc;
   logic [7:0] a0, a1, a2, a3;

   always_comb begin
      s  = to_state(data);
      sb = '0;
      sr = '0;
      mc = '0;
      a0 = '0;
      a1 = '0;
      a2 = '0;
      a3 = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            sb[c][r] = sbox(s[c][r]);
         end
      end
      // Row r rotates left by r columns.
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            sr[c][r] = sb[(c + r) % 4][r];
         end
      end
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = sr[c][0];
         a1 = sr[c][1];
         a2 = sr[c][2];
         a3 = sr[c][3];
         mc[c][0] = gf_mul2(a0) ^ gf_mul2(a1) ^ a1 ^ a2 ^ a3;
         mc[c][1] = a0 ^ gf_mul2(a1) ^ gf_mul2(a2) ^ a2 ^ a3;
         mc[c][2] = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul2(a3) ^ a3;
         mc[c][3] = gf_mul2(a0) ^ a0 ^ a1 ^ a2 ^ gf_mul2(a3);
      end
      result = from_state(last ? sr : mc) ^ rkey;
   end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core, KEY_BITS = 128/192/256.
// Expands the key once (one 32-bit word per cycle) into a round-key store,
// then encrypts one round per cycle.
// Ports:
//   clk, rst              - rising-edge clock, async active-high reset
//   key_valid/key_ready   - key handshake; key_in left-justified (256 bits)
//   in_valid/in_ready     - plaintext handshake; in_block byte 0 in [127:120]
//   out_valid/out_ready   - ciphertext handshake; out_block held until taken
//   key_loaded            - a complete key schedule is stored
module aes_iter_core
   import aes_pkg::*;
#(
   parameter int unsigned KEY_BITS = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [255:0] key_in,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block,
   output logic         key_loaded
);

   localparam int unsigned NK = KEY_BITS / 32;
   localparam int unsigned NR = NK + 6;
   localparam int unsigned NW = 4 * (NR + 1);

   localparam logic [5:0] NK_W     = 6'(NK);
   localparam logic [5:0] LAST_W   = 6'(NW - 1);
   localparam logic [2:0] KPOS_MAX = 3'(NK - 1);
   localparam logic [3:0] NR_R     = 4'(NR);

   generate
      if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
         $fatal(1, "aes_iter_core: KEY_BITS must be 128, 192 or 256");
      end
      if (KEY_BITS < 256) begin : g_key_pad
         logic unused_key_bits;
         assign unused_key_bits = ^key_in[255-KEY_BITS:0];
      end
   endgenerate

   aes_fsm_e state, nxt;

   logic [31:0]  w [0:NW-1];
   logic [5:0]   widx;
   logic [2:0]   kpos;
   logic [3:0]   rci;
   logic [3:0]   rnd;
   logic [127:0] st;

   logic load_key, load_blk, kexp_step, run_step;

   logic [31:0]  prev, old, rot_sel, sub, temp, new_word;
   logic [3:0]   rk_round;
   logic [5:0]   rk_base;
   logic [127:0] rk, round_out;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= NOKEY;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt       = state;
      key_ready = 1'b0;
      in_ready  = 1'b0;
      load_key  = 1'b0;
      load_blk  = 1'b0;
      kexp_step = 1'b0;
      run_step  = 1'b0;
      case (state)
         NOKEY: begin
            key_ready = 1'b1;
            if (key_valid) begin
               load_key = 1'b1;
               nxt      = KEXP;
            end
         end
         KEXP: begin
            kexp_step = 1'b1;
            if (widx == LAST_W) nxt = READY;
         end
         READY: begin
            key_ready = 1'b1;
            in_ready  = !key_valid;
            if (key_valid) begin
               load_key = 1'b1;
               nxt      = KEXP;
            end else if (in_valid) begin
               load_blk = 1'b1;
               nxt      = RUN;
            end
         end
         RUN: begin
            run_step = 1'b1;
            if (rnd == NR_R) nxt = DONE;
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  load_blk = 1'b1;
                  nxt      = RUN;
               end else begin
                  nxt = READY;
               end
            end
         end
         default: nxt = NOKEY;
      endcase
   end

   assign out_valid  = (state == DONE);
   assign key_loaded = (state == READY) || (state == RUN) || (state == DONE);

   // ---------------- Key expansion ----------------
   // kpos tracks i % NK and rci tracks i / NK incrementally.
   always_comb begin
      prev    = w[widx - 6'd1];
      old     = w[widx - NK_W];
      rot_sel = (kpos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
      sub     = {sbox(rot_sel[31:24]), sbox(rot_sel[23:16]),
                 sbox(rot_sel[15:8]),  sbox(rot_sel[7:0])};
      if (kpos == 3'd0) begin
         temp = sub ^ {RCON[rci], 24'h000000};
      end else if (NK == 8 && kpos == 3'd4) begin
         temp = sub;
      end else begin
         temp = prev;
      end
      new_word = old ^ temp;
   end

   // Round-key store is deliberately not reset.
   always_ff @(posedge clk) begin
      if (load_key) begin
         for (int unsigned k = 0; k < NK; k++) begin
            w[k] <= key_in[255 - 32*k -: 32];
         end
      end else if (kexp_step) begin
         w[widx] <= new_word;
      end
   end

   // ---------------- Encryption datapath ----------------
   // Outside RUN the only key needed is rk0 (initial AddRoundKey on accept).
   assign rk_round = (state == RUN) ? rnd : 4'd0;
   assign rk_base  = {rk_round, 2'b00};
   assign rk       = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};

   aes_enc_round u_round (
      .data   (st),
      .rkey   (rk),
      .last   (rnd == NR_R),
      .result (round_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         widx      <= NK_W;
         kpos      <= '0;
         rci       <= 4'd1;
         rnd       <= '0;
         st        <= '0;
         out_block <= '0;
      end else begin
         if (load_key) begin
            widx <= NK_W;
            kpos <= '0;
            rci  <= 4'd1;
         end else if (kexp_step) begin
            widx <= widx + 6'd1;
            if (kpos == KPOS_MAX) begin
               kpos <= '0;
               rci  <= rci + 4'd1;
            end else begin
               kpos <= kpos + 3'd1;
            end
         end

         if (load_blk) begin
            st  <= in_block ^ rk;
            rnd <= 4'd1;
         end else if (run_step) begin
            st <= round_out;
            if (rnd == NR_R) begin
               out_block <= round_out;
            end else begin
               rnd <= rnd + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed testbench for aes_iter_core: one instance per key size
// (index 0 = AES-128, 1 = AES-192, 2 = AES-256).
module tb_aes_iter_core;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2:0]   kv, kr, iv, ir, ov, orr, kl;
   logic [255:0] kin [3];
   logic [127:0] ib  [3];
   logic [127:0] ob  [3];

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] B1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] E1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] E192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] E256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B2  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] E2  = 128'h3925841d02dc09fbdc118597196a0b32;

   aes_iter_core #(.KEY_BITS(128)) u128 (
      .clk(clk), .rst(rst), .key_valid(kv[0]), .key_ready(kr[0]), .key_in(kin[0]),
      .in_valid(iv[0]), .in_ready(ir[0]), .in_block(ib[0]), .out_valid(ov[0]),
      .out_ready(orr[0]), .out_block(ob[0]), .key_loaded(kl[0]));
   aes_iter_core #(.KEY_BITS(192)) u192 (
      .clk(clk), .rst(rst), .key_valid(kv[1]), .key_ready(kr[1]), .key_in(kin[1]),
      .in_valid(iv[1]), .in_ready(ir[1]), .in_block(ib[1]), .out_valid(ov[1]),
      .out_ready(orr[1]), .out_block(ob[1]), .key_loaded(kl[1]));
   aes_iter_core #(.KEY_BITS(256)) u256 (
      .clk(clk), .rst(rst), .key_valid(kv[2]), .key_ready(kr[2]), .key_in(kin[2]),
      .in_valid(iv[2]), .in_ready(ir[2]), .in_block(ib[2]), .out_valid(ov[2]),
      .out_ready(orr[2]), .out_block(ob[2]), .key_loaded(kl[2]));

   // ---------------- Reference AES-128 (independently derived S-box) ----------------
   logic [7:0] ms [256];

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic hi;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b  = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox;
      logic [7:0] inv, xb, yb;
      for (int x = 0; x < 256; x++) begin
         xb  = 8'(x);
         inv = 8'h00;
         if (x != 0) begin
            for (int y = 1; y < 256; y++) begin
               yb = 8'(y);
               if (gmul(xb, yb) == 8'h01) inv = yb;
            end
         end
         ms[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] model_aes128(input logic [127:0] key, input logic [127:0] blk);
      logic [31:0] wk [44];
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [31:0] tmp;
      logic [7:0]  rc, a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) wk[i] = key[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = wk[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {ms[tmp[31:24]] ^ rc, ms[tmp[23:16]], ms[tmp[15:8]], ms[tmp[7:0]]};
            rc  = gmul(rc, 8'h02);
         end
         wk[i] = wk[i-4] ^ tmp;
      end
      for (int k = 0; k < 16; k++) s[k] = blk[127 - 8*k -: 8] ^ wk[k/4][31 - 8*(k%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int k = 0; k < 16; k++) t[k] = ms[s[k]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int k = 0; k < 16; k++) s[k] = s[k] ^ wk[4*rnd + k/4][31 - 8*(k%4) -: 8];
      end
      for (int k = 0; k < 16; k++) res[127 - 8*k -: 8] = s[k];
      return res;
   endfunction

   // ---------------- Stimulus helpers (no checking) ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input int d, input logic [255:0] key, output int cyc);
      kin[d] = key;
      kv[d]  = 1'b1;
      tick();
      kv[d]  = 1'b0;
      cyc    = 0;
      while (kl[d] !== 1'b1 && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask

   task automatic run_block(input int d, input logic [127:0] blk, output int lat,
                            output logic [127:0] res);
      ib[d] = blk;
      iv[d] = 1'b1;
      tick();
      iv[d] = 1'b0;
      lat   = 0;
      while (ov[d] !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      res = ob[d];
   endtask

   task automatic consume(input int d);
      orr[d] = 1'b1;
      tick();
      orr[d] = 1'b0;
   endtask

   // ---------------- Tests ----------------
   task automatic test_reset;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({kr[d], ir[d], ov[d], kl[d], ob[d]} !== {1'b1, 1'b0, 1'b0, 1'b0, 128'h0}) begin
            errors++;
            $display("FAIL reset[%0d]: key_ready=%b in_ready=%b out_valid=%b key_loaded=%b out_block=%h, want 1 0 0 0 0",
                     d, kr[d], ir[d], ov[d], kl[d], ob[d]);
         end
      end
   endtask

   task automatic test_aes128;
      int cyc, lat;
      logic [127:0] res;
      // Junk in the unused low half of key_in must be ignored.
      load_key(0, {K1, 128'hdeadbeefcafef00d0123456789abcdef}, cyc);
      checks++;
      if (cyc !== 40) begin errors++; $display("FAIL aes128 kexp cycles: got %0d want 40", cyc); end
      checks++;
      if (ir[0] !== 1'b1) begin errors++; $display("FAIL aes128 in_ready after kexp: got %b want 1", ir[0]); end
      run_block(0, B1, lat, res);
      checks++;
      if (lat !== 10) begin errors++; $display("FAIL aes128 latency: got %0d want 10", lat); end
      checks++;
      if (res !== E1) begin errors++; $display("FAIL aes128 out_block: got %h want %h", res, E1); end
      consume(0);
      checks++;
      if (ov[0] !== 1'b0) begin errors++; $display("FAIL aes128 out_valid after consume: got %b want 0", ov[0]); end
   endtask

   task automatic test_aes192;
      int cyc, lat;
      logic [127:0] res;
      load_key(1, {K192, 64'hffffffffffffffff}, cyc);
      checks++;
      if (cyc !== 46) begin errors++; $display("FAIL aes192 kexp cycles: got %0d want 46", cyc); end
      run_block(1, B1, lat, res);
      checks++;
      if (lat !== 12) begin errors++; $display("FAIL aes192 latency: got %0d want 12", lat); end
      checks++;
      if (res !== E192) begin errors++; $display("FAIL aes192 out_block: got %h want %h", res, E192); end
      consume(1);
   endtask

   task automatic test_aes256;
      int cyc, lat;
      logic [127:0] res;
      load_key(2, K256, cyc);
      checks++;
      if (cyc !== 52) begin errors++; $display("FAIL aes256 kexp cycles: got %0d want 52", cyc); end
      run_block(2, B1, lat, res);
      checks++;
      if (lat !== 14) begin errors++; $display("FAIL aes256 latency: got %0d want 14", lat); end
      checks++;
      if (res !== E256) begin errors++; $display("FAIL aes256 out_block: got %h want %h", res, E256); end
      consume(2);
   endtask

   task automatic test_backpressure;
      int cyc, lat, bad;
      logic [127:0] res;
      load_key(0, {K2, 128'h0}, cyc);
      checks++;
      if (cyc !== 40) begin errors++; $display("FAIL bp kexp cycles: got %0d want 40", cyc); end
      run_block(0, B2, lat, res);
      checks++;
      if (res !== E2) begin errors++; $display("FAIL bp out_block: got %h want %h", res, E2); end
      bad = 0;
      repeat (20) begin
         tick();
         if (ob[0] !== E2 || ov[0] !== 1'b1 || ir[0] !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL bp hold: %0d bad cycles, want 0", bad); end
      ib[0]  = B2;
      iv[0]  = 1'b1;
      orr[0] = 1'b1;
      #1;
      checks++;
      if (ir[0] !== 1'b1) begin errors++; $display("FAIL bp in_ready on release: got %b want 1", ir[0]); end
      tick();
      iv[0]  = 1'b0;
      orr[0] = 1'b0;
      checks++;
      if (ov[0] !== 1'b0) begin errors++; $display("FAIL bp out_valid after release: got %b want 0", ov[0]); end
      lat = 0;
      while (ov[0] !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      checks++;
      if (lat !== 10) begin errors++; $display("FAIL bp no-bubble latency: got %0d want 10", lat); end
      checks++;
      if (ob[0] !== E2) begin errors++; $display("FAIL bp second out_block: got %h want %h", ob[0], E2); end
      consume(0);
   endtask

   task automatic test_key_priority;
      int n, lat;
      kin[0] = {K1, 128'h0};
      kv[0]  = 1'b1;
      ib[0]  = B1;
      iv[0]  = 1'b1;
      #1;
      checks++;
      if ({kr[0], ir[0]} !== 2'b10) begin
         errors++;
         $display("FAIL prio ready: key_ready=%b in_ready=%b want 1 0", kr[0], ir[0]);
      end
      tick();
      kv[0] = 1'b0;
      checks++;
      if ({kl[0], ir[0]} !== 2'b00) begin
         errors++;
         $display("FAIL prio after edge: key_loaded=%b in_ready=%b want 0 0", kl[0], ir[0]);
      end
      n = 0;
      while (ir[0] !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 40) begin errors++; $display("FAIL prio kexp cycles: got %0d want 40", n); end
      tick();
      iv[0] = 1'b0;
      lat = 0;
      while (ov[0] !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      checks++;
      if (lat !== 10) begin errors++; $display("FAIL prio latency: got %0d want 10", lat); end
      checks++;
      if (ob[0] !== E1) begin errors++; $display("FAIL prio out_block: got %h want %h", ob[0], E1); end
      consume(0);
   endtask

   task automatic test_reset_mid_run;
      int cyc, lat;
      logic [127:0] res;
      ib[0] = B1;
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      repeat (4) tick();
      checks++;
      if ({ov[0], ob[0]} !== {1'b0, E1}) begin
         errors++;
         $display("FAIL midrun before reset: out_valid=%b out_block=%h want 0 %h", ov[0], ob[0], E1);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({ov[0], ob[0], kl[0], kr[0], ir[0]} !== {1'b0, 128'h0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL midrun async reset: out_valid=%b out_block=%h key_loaded=%b key_ready=%b in_ready=%b want 0 0 0 1 0",
                  ov[0], ob[0], kl[0], kr[0], ir[0]);
      end
      tick();
      rst = 1'b0;
      tick();
      load_key(0, {K1, 128'h0}, cyc);
      run_block(0, B1, lat, res);
      checks++;
      if ({cyc, lat} !== {32'd40, 32'd10}) begin
         errors++;
         $display("FAIL midrun reload timing: kexp=%0d latency=%0d want 40 10", cyc, lat);
      end
      checks++;
      if (res !== E1) begin errors++; $display("FAIL midrun reload out_block: got %h want %h", res, E1); end
      consume(0);
   endtask

   task automatic test_back_to_back;
      logic [127:0] blk [8];
      logic [127:0] expv [8];
      logic [127:0] mref;
      int lat;
      mref = model_aes128(K1, B1);
      checks++;
      if (mref !== E1) begin errors++; $display("FAIL model reference: got %h want %h", mref, E1); end
      for (int j = 0; j < 8; j++) begin
         blk[j]  = B1 ^ {16{8'(8'h1d * j + 8'h07 * (j / 2))}};
         expv[j] = model_aes128(K1, blk[j]);
      end
      orr[0] = 1'b1;
      ib[0]  = blk[0];
      iv[0]  = 1'b1;
      tick();
      for (int j = 0; j < 8; j++) begin
         lat = 0;
         while (ov[0] !== 1'b1 && lat < 30) begin
            tick();
            lat++;
         end
         checks++;
         if (lat !== 10) begin errors++; $display("FAIL b2b[%0d] latency: got %0d want 10", j, lat); end
         checks++;
         if (ob[0] !== expv[j]) begin errors++; $display("FAIL b2b[%0d] out_block: got %h want %h", j, ob[0], expv[j]); end
         if (j < 7) ib[0] = blk[j+1];
         else iv[0] = 1'b0;
         tick();
      end
      checks++;
      if (ov[0] !== 1'b0) begin errors++; $display("FAIL b2b drain out_valid: got %b want 0", ov[0]); end
      orr[0] = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      kv  = '0;
      iv  = '0;
      orr = '0;
      for (int d = 0; d < 3; d++) begin
         kin[d] = '0;
         ib[d]  = '0;
      end
      build_sbox();
      tick();
      tick();
      test_reset();
      rst = 1'b0;
      tick();
      test_aes128();
      test_aes192();
      test_aes256();
      test_backpressure();
      test_key_priority();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
Iterative, clocked AES encryption core, parametrised for key length 128/192/256.
- Expands the key once into an internal round-key store, one 32-bit word per cycle.
- Then encrypts 128-bit blocks at one round per cycle, with valid/ready handshakes on key, input and output.
- Successor to the fully combinational unrolled AES-128 top: much smaller area, supports all three FIPS-197 key sizes, and is usable on a streaming bus.

Parameters:
KEY_BITS, 128, key length; legal values 128/192/256; any other value is an elaboration error.
NK, KEY_BITS/32, key words (derived, not overridable).
NR, NK+6, rounds (derived: 10/12/14).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
key_valid  in  1  key_in valid
key_ready  out  1  core accepts a key this cycle
key_in  in  256  key, left-justified; bits [255:256-KEY_BITS] used, the rest ignored
in_valid  in  1  in_block valid
in_ready  out  1  core accepts a block this cycle
in_block  in  128  plaintext; [127:120] = FIPS-197 byte 0, column-major
out_valid  out  1  out_block valid
out_ready  in  1  sink accepts out_block
out_block  out  128  ciphertext, same byte order as in_block
key_loaded  out  1  a complete key schedule is stored

Behaviour:
- Reset: async on rst high. State=NOKEY; key_ready=1 after reset; in_ready=0, out_valid=0, out_block=0, key_loaded=0. Round-key store is not cleared.
- Transfer rule: a transfer occurs on a rising edge where valid && ready.

FSM states: NOKEY, KEXP, READY, RUN, DONE.
- NOKEY: key_ready=1, in_ready=0. Key transfer -> latch NK words into store w[0..NK-1], word counter i=NK -> KEXP.
- KEXP: key_ready=0, in_ready=0. One word per cycle, per FIPS-197:
  - w[i] = w[i-NK] ^ temp;
  - temp = SubWord(RotWord(w[i-1])) ^ Rcon[i/NK] when i%NK==0;
  - temp = SubWord(w[i-1]) when NK==8 and i%8==4;
  - otherwise temp = w[i-1].
  - Leave after i = 4*(NR+1)-1: 40/46/52 cycles for 128/192/256. Then -> READY, key_loaded=1.
- READY: key_ready=1; in_ready = !key_valid (key has priority over data in the same cycle).
  - Key transfer -> key_loaded=0 -> KEXP.
  - Block transfer -> state reg = in_block ^ rk0, round counter r=1 -> RUN.
- RUN: on each edge apply round r: SubBytes, ShiftRows, MixColumns, AddRoundKey rk_r. MixColumns is skipped when r==NR.
  - After the r==NR edge: out_block=result, out_valid=1 -> DONE.
  - Latency: out_valid rises exactly NR edges after the accept edge.
- DONE: out_valid=1 and out_block held stable until out_ready. key_ready=0.
  - in_ready = out_ready: a new block may be accepted on the same edge the result is consumed, which goes straight to RUN with no bubble. Block throughput is 1 per NR+1 cycles.
  - out_ready without in_valid -> READY, out_valid=0.
- Keys are never accepted in KEXP, RUN or DONE.
- Round key rk_r = w[4r..4r+3]; rk word 0 occupies [127:96].
- Input stability: key_in and in_block are sampled only on the transfer edge; the core holds no reference to them afterwards.
- Reset mid-operation (KEXP/RUN/DONE) returns to NOKEY; an in-flight block is discarded; a key must be reloaded.
- Backpressure: out_ready held low indefinitely holds DONE with out_block unchanged; no data is lost.

Decomposition:
Package aes_pkg holds:
- sbox function (256-entry constant);
- xtime / gf_mul2 function;
- RCON[1:10] constant;
- state-matrix typedef (logic [7:0] [0:3][0:3]) and pack/unpack functions for 128-bit vectors;
- FSM enum.

One sub-module, aes_enc_round: combinational round (16 S-boxes, ShiftRows, MixColumns, AddRoundKey) with a `last` input that bypasses MixColumns. It is instantiated once.
Key expansion uses 4 extra S-box lookups inside aes_iter_core.
Round-key store: array of 4*(NR+1) 32-bit registers.

Test Plan:
1. KEY_BITS=128: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a. key_loaded rises 40 cycles after the key transfer; out_valid rises 10 edges after the block transfer.
2. KEY_BITS=192: key 000102…1617, same block -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 12. KEY_BITS=256: key 000102…1e1f -> 8ea2b7ca516745bfeafc49904b496089, latency 14, KEXP 52 cycles.
3. KEY_BITS=128: key 2b7e151628aed2a6abf7158809cf4f3c, block 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Hold out_ready=0 for 20 cycles: out_block stable, in_ready=0. Release with in_valid=1 -> next block accepted on the same edge, no bubble.
4. In READY, assert key_valid and in_valid together -> key accepted, block not accepted. After KEXP the block is accepted and encrypted under the new key.
5. Assert rst mid-RUN (round 5) -> out_valid=0, out_block=0, key_loaded=0, key_ready=1 immediately (async). After reload, vector 1 still passes.
6. Back-to-back 8 blocks with out_ready=1 constantly -> one result per 11 cycles, each matching the reference model, in order.
